// File: rtl/seg_scan_if.sv
// seg_scan_if: control, score and display signals between a controller and seg_scan_engine.
interface seg_scan_if #(
  parameter int N_DIGITS = 8,
  parameter int SCORE_W  = 27
);
  logic [1:0]            mode;
  logic [2*N_DIGITS-1:0] map;
  logic                  jump;
  logic [SCORE_W-1:0]    score;
  logic                  score_load;
  logic                  busy;
  logic                  bcd_valid;
  logic [N_DIGITS-1:0]   AN;
  logic [7:0]            S;
  modport master (output mode, map, jump, score, score_load, input busy, bcd_valid, AN, S);
  modport slave  (input mode, map, jump, score, score_load, output busy, bcd_valid, AN, S);
endinterface

// File: rtl/seg_scan_engine.sv
// seg_scan_engine: multiplexed 7-segment scanner with a serial double-dabble score converter.
module seg_scan_engine #(
  parameter int N_DIGITS   = 8,
  parameter int SCAN_DIV_W = 16,
  parameter int BLANK_CYC  = 64,
  parameter int SCORE_W    = 27
) (
  input logic       CLK100MHZ,
  input logic       CPU_RESETN,
  seg_scan_if.slave bus
);
  localparam int BW = 4 * N_DIGITS;
  localparam logic [63:0] LIMIT = 64'(10 ** N_DIGITS);
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [7:0] LANE [4] = '{8'hFF, 8'hA3, 8'h9C, 8'h7F};
  localparam logic [7:0] MSG [8]  = '{8'hBF, 8'h92, 8'h87, 8'h88, 8'hAF, 8'h87, 8'hBF, 8'hBF};
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                r_state, w_state_nx;
  logic [SCAN_DIV_W-1:0] r_div;
  logic [2:0]            r_d;
  logic [N_DIGITS-1:0]   r_an, w_an;
  logic [7:0]            r_s, w_seg, r_cnt;
  logic [SCORE_W-1:0]    r_bin, r_pend_val, w_load_val;
  logic [BW-1:0]         r_bcd, r_disp, w_adj;
  logic                  r_sat, r_pend, r_valid, w_start, w_lz, w_last;
  logic [3:0]            w_nib;
  logic [1:0]            w_code;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_div <= '0;
      r_d   <= '0;
      r_an  <= '1;
      r_s   <= '1;
    end else begin
      r_div <= r_div + SCAN_DIV_W'(1);
      if (&r_div) r_d <= (r_d == 3'(N_DIGITS - 1)) ? 3'd0 : r_d + 3'd1;
      r_an  <= w_an;
      r_s   <= w_seg;
    end
  end

  // digits above the most significant nonzero one are blanked; digit 0 always shows
  always_comb begin
    w_nib  = r_disp[4*r_d +: 4];
    w_code = bus.map[2*r_d +: 2];
    w_lz   = (r_d != 3'd0) && ((r_disp >> (4*r_d)) == '0);
    w_last = r_d == 3'(N_DIGITS - 1);
    w_seg  = bus.mode == 2'd0 ? (w_lz ? 8'hFF : HEX[w_nib]) :
             bus.mode == 2'd1 ? (w_last ? (bus.jump && w_code == 2'd1 ? 8'hA1 : bus.jump ? 8'hBD : 8'hF3)
                                        : LANE[w_code]) :
             bus.mode == 2'd2 ? MSG[3'(N_DIGITS - 1) - r_d] : 8'hFF;
    w_an   = (bus.mode == 2'd3 || r_div < SCAN_DIV_W'(BLANK_CYC)) ? '1 : ~(N_DIGITS'(1) << r_d);
  end

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < N_DIGITS; i++)
      w_adj[4*i +: 4] = r_bcd[4*i +: 4] >= 4'd5 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_load_val = bus.score;
    case (r_state)
      IDLE: if (bus.score_load) begin
        w_start    = 1'b1;
        w_state_nx = SHIFT;
      end
      SHIFT: if (r_cnt == 8'(SCORE_W - 1)) w_state_nx = COMMIT;
      COMMIT: begin
        w_start    = bus.score_load || r_pend;
        w_load_val = bus.score_load ? bus.score : r_pend_val;
        w_state_nx = w_start ? SHIFT : IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // a load arriving in COMMIT is consumed directly, so the newest value always wins
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_disp     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_valid <= r_state == COMMIT;
      if (w_start) begin
        r_bin <= w_load_val;
        r_bcd <= '0;
        r_cnt <= '0;
        r_sat <= 64'(w_load_val) >= LIMIT;
      end else if (r_state == SHIFT) begin
        r_bin <= r_bin << 1;
        r_bcd <= {w_adj[BW-2:0], r_bin[SCORE_W-1]};
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == COMMIT) r_disp <= r_sat ? {N_DIGITS{4'h9}} : r_bcd;
      r_pend     <= r_state == COMMIT ? 1'b0 : r_pend | (bus.score_load && r_state != IDLE);
      r_pend_val <= (bus.score_load && r_state != IDLE) ? bus.score : r_pend_val;
    end
  end

  assign bus.AN        = r_an;
  assign bus.S         = r_s;
  assign bus.busy      = r_state != IDLE;
  assign bus.bcd_valid = r_valid;
endmodule

// File: tb/tb_seg_scan_engine.sv
// tb_seg_scan_engine: directed stimulus with a queue-based scoreboard checking conversion timing and displayed glyphs.
module tb_seg_scan_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.N_DIGITS(8), .SCORE_W(27)) bus ();
  seg_scan_if #(.N_DIGITS(5), .SCORE_W(27)) bus2 ();

  seg_scan_engine #(.N_DIGITS(8), .SCAN_DIV_W(4), .BLANK_CYC(2), .SCORE_W(27)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .bus(bus));
  seg_scan_engine #(.N_DIGITS(5), .SCAN_DIV_W(4), .BLANK_CYC(2), .SCORE_W(27)) dut2 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .bus(bus2));

  typedef struct {
    int          kind;
    int          id;
    int          exp_cyc;
    bit          glyph;
    logic [63:0] g;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, want_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic scan(input int id, input logic [63:0] exp);
    logic [63:0] got = '1;
    logic [7:0] seen = '0;
    int n = 0;
    @(negedge clk);
    while (seen != 8'hFF && n < 300) begin
      for (int i = 0; i < 8; i++)
        if (bus.AN == ~(8'd1 << i)) begin
          got[8*i +: 8] = bus.S;
          seen[i] = 1'b1;
        end
      @(negedge clk);
      n++;
    end
    if (seen != 8'hFF) got = 'x;
    check($sformatf("glyphs#%0d", id), got, exp);
  endtask

  task automatic blank_watch(input int id);
    int viol = 0;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (bus.AN != 8'hFF || bus.S != 8'hFF) viol++;
      @(negedge clk);
    end
    check($sformatf("blank#%0d", id), viol, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.bcd_valid) begin
        if (sb.size() == 0 || sb[0].kind != 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bcd_valid: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          check($sformatf("valid_cycle#%0d", e.id), cyc, e.exp_cyc);
          if (e.glyph) scan(e.id, e.g);
          done_cnt++;
        end
      end else if (sb.size() != 0 && sb[0].kind != 0) begin
        e = sb.pop_front();
        if (e.kind == 1) scan(e.id, e.g);
        else blank_watch(e.id);
        done_cnt++;
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (done_cnt < want_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < want_done) begin
      total++;
      bad++;
      $display("FAIL scoreboard_timeout: done=%0d expected %0d", done_cnt, want_done);
      sb.delete();
      done_cnt = want_done;
    end
  endtask

  task automatic load(input logic [26:0] v, output int lc);
    @(negedge clk);
    bus.score = v;
    bus.score_load = 1'b1;
    lc = cyc;
    @(negedge clk);
    bus.score_load = 1'b0;
  endtask

  task automatic convert(input int id, input logic [26:0] v, input logic [63:0] g);
    int lc;
    load(v, lc);
    sb.push_back('{0, id, lc + 29, 1'b1, g});
    want_done++;
    wait_done();
  endtask

  task automatic snap(input int id, input int kind, input logic [63:0] g);
    repeat (2) @(negedge clk);
    sb.push_back('{kind, id, 0, 1'b0, g});
    want_done++;
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lc, blank_run, lit_run, exp_d, slots, multi, nvalid;
    logic [4:0] lit_an, want_an;
    bus.mode = 2'd0; bus.map = '0; bus.jump = 1'b0; bus.score = '0; bus.score_load = 1'b0;
    bus2.mode = 2'd0; bus2.map = '0; bus2.jump = 1'b0; bus2.score = '0; bus2.score_load = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an", bus.AN, 8'hFF);
    check("reset_s", bus.S, 8'hFF);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_valid", bus.bcd_valid, 1'b0);
    check("reset_an5", bus2.AN, 5'h1F);
    rst_n = 1'b1;
    @(posedge clk);
    blank_run = 0; lit_run = 0; exp_d = 0; slots = 0; multi = 0; lit_an = '1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ($countones(~bus2.AN) > 1) multi++;
      if (bus2.AN == 5'h1F) begin
        if (lit_run > 0) begin
          want_an = ~(5'd1 << exp_d);
          check("slot_len", lit_run, 14);
          check($sformatf("slot_digit%0d", slots), lit_an, want_an);
          exp_d = (exp_d + 1) % 5;
          slots++;
          lit_run = 0;
        end
        blank_run++;
      end else begin
        if (blank_run > 0) begin
          check("blank_len", blank_run, 2);
          blank_run = 0;
        end
        lit_run++;
        lit_an = bus2.AN;
      end
    end
    check("multi_anode", multi, 0);
    check("slots_seen", slots, 6);

    snap(1, 1, 64'hFFFFFFFFFFFFFFC0);
    convert(2, 27'd12345678, 64'hF9A4B0999282F880);
    convert(3, 27'd0, 64'hFFFFFFFFFFFFFFC0);
    convert(4, 27'd305, 64'hFFFFFFFFFFB0C092);
    convert(5, 27'd99999999, 64'h9090909090909090);
    convert(6, 27'd100000000, 64'h9090909090909090);
    convert(7, 27'h7FFFFFF, 64'h9090909090909090);
    convert(8, 27'd7, 64'hFFFFFFFFFFFFFFF8);

    load(27'd111, lc);
    sb.push_back('{0, 9, lc + 29, 1'b0, 64'h0});
    sb.push_back('{0, 10, lc + 57, 1'b1, 64'hFFFFFFFFFFA4A4A4});
    want_done += 2;
    repeat (3) @(negedge clk);
    check("busy_during_shift", bus.busy, 1'b1);
    load(27'd222, nvalid);
    wait_done();

    bus.mode = 2'd1; bus.map = 16'h4000; bus.jump = 1'b1;
    snap(11, 1, 64'hA1FFFFFFFFFFFFFF);
    bus.jump = 1'b0;
    snap(12, 1, 64'hF3FFFFFFFFFFFFFF);
    bus.map = 16'h00E4; bus.jump = 1'b1;
    snap(13, 1, 64'hBDFFFFFF7F9CA3FF);
    bus.mode = 2'd2;
    snap(14, 1, 64'hBF928788AF87BFBF);
    bus.mode = 2'd3;
    snap(15, 2, 64'h0);

    bus.mode = 2'd0; bus.jump = 1'b0; bus.map = '0;
    load(27'd999, lc);
    repeat (8) @(negedge clk);
    check("busy_before_reset", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy", bus.busy, 1'b0);
    check("async_reset_s", bus.S, 8'hFF);
    check("async_reset_an", bus.AN, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.bcd_valid) nvalid++;
    end
    check("no_valid_after_reset", nvalid, 0);
    snap(16, 1, 64'hFFFFFFFFFFFFFFC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
